// File: rtl/diagv2_syscall_unit_if.sv
// Signal bundle between the diag-v2 core/dmem/console sink and the syscall unit.
// The unit uses the slave modport; the core-side environment uses master.
interface diagv2_syscall_unit_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic              ecall_i;
    logic [DATA_W-1:0] sys_id_i;
    logic [DATA_W-1:0] arg0_i;
    logic              halt_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_ready_i;
    logic              exit_valid_o;
    logic [DATA_W-1:0] exit_code_o;
    logic [1:0]        err_o;

    // tx handshake: a byte moves on a rising edge with tx_valid_o & tx_ready_i; once raised,
    // tx_valid_o/tx_data_o stay put until that edge, and tx_ready_i alone does nothing.
    modport slave (
        input  ecall_i, sys_id_i, arg0_i, mem_rdata_i, tx_ready_i,
        output halt_o, mem_req_o, mem_addr_o, tx_valid_o, tx_data_o,
        output exit_valid_o, exit_code_o, err_o
    );

    modport master (
        output ecall_i, sys_id_i, arg0_i, mem_rdata_i, tx_ready_i,
        input  halt_o, mem_req_o, mem_addr_o, tx_valid_o, tx_data_o,
        input  exit_valid_o, exit_code_o, err_o
    );
endinterface

// File: rtl/diagv2_syscall_unit.sv
// Hardware ecall handler: stalls the core, decodes a7, streams PRINT/PUTC bytes
// from a private dmem read port and latches the EXIT code.
module diagv2_syscall_unit #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 32,
    parameter int MAX_STR     = 1024,
    parameter int SYS_PRINT   = 4,
    parameter int SYS_EXIT    = 93,
    parameter int SYS_PUTC    = 11,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    diagv2_syscall_unit_if.slave   bus,
    output logic [2:0]             dbg_state
);
    localparam int B     = DATA_W / 8;
    localparam int OB    = $clog2(B);
    localparam int CNT_W = $clog2(MAX_STR + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_EMIT1, S_DONE, S_EXITED, S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] line_q;
    logic [OB-1:0]     off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] line_buf_q;
    logic [7:0]        putc_q;
    logic              exit_valid_q;
    logic [DATA_W-1:0] exit_code_q;
    logic [1:0]        err_q;

    logic       accept, is_print, is_putc, is_exit;
    logic [7:0] cur_byte;
    logic       at_nul, at_max, last_off;
    logic       tx_valid, xfer;
    logic [7:0] tx_data;

    assign accept   = (state_q == S_IDLE) & bus.ecall_i;
    assign is_print = bus.sys_id_i == DATA_W'(SYS_PRINT);
    assign is_putc  = bus.sys_id_i == DATA_W'(SYS_PUTC);
    assign is_exit  = bus.sys_id_i == DATA_W'(SYS_EXIT);

    assign cur_byte = line_buf_q[{off_q, 3'b000} +: 8];
    assign at_nul   = cur_byte == 8'h00;
    assign at_max   = cnt_q == CNT_W'(MAX_STR);
    assign last_off = off_q == OB'(B - 1);
    assign xfer     = tx_valid & bus.tx_ready_i;

    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (bus.ecall_i) begin
                    if (is_print)     state_d = S_FETCH;
                    else if (is_putc) state_d = S_EMIT1;
                    else if (is_exit) state_d = S_EXITED;
                    else              state_d = STOP_ON_ERR ? S_HALTED : S_DONE;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_SCAN;
            S_SCAN: begin
                if (at_nul || at_max) begin
                    state_d = S_DONE;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = cur_byte;
                    // Leaving the last byte of a line needs the next line fetched first.
                    if (bus.tx_ready_i && last_off) state_d = S_FETCH;
                end
            end
            S_EMIT1: begin
                tx_valid = 1'b1;
                tx_data  = putc_q;
                if (bus.tx_ready_i) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            line_buf_q   <= '0;
            putc_q       <= 8'h00;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
            err_q        <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (is_print) begin
                    line_q <= bus.arg0_i[ADDR_W+OB-1:OB];
                    off_q  <= bus.arg0_i[OB-1:0];
                    cnt_q  <= '0;
                end else if (is_putc) begin
                    putc_q <= bus.arg0_i[7:0];
                end else if (is_exit) begin
                    exit_code_q  <= bus.arg0_i;
                    exit_valid_q <= 1'b1;
                end else begin
                    err_q[0] <= 1'b1;
                end
            end
            if (state_q == S_WAIT) line_buf_q <= bus.mem_rdata_i;
            if (state_q == S_SCAN) begin
                if (xfer) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    off_q <= off_q + OB'(1);
                    if (last_off) line_q <= line_q + ADDR_W'(1);
                end
                if (!at_nul && at_max) err_q[1] <= 1'b1;
            end
        end
    end

    // Stall is combinational so the core freezes in the very cycle it presents the ecall.
    assign bus.halt_o       = (state_q == S_IDLE) ? bus.ecall_i : 1'b1;
    assign bus.mem_req_o    = state_q == S_FETCH;
    assign bus.mem_addr_o   = (state_q == S_FETCH) ? line_q : '0;
    assign bus.tx_valid_o   = tx_valid;
    assign bus.tx_data_o    = tx_data;
    assign bus.exit_valid_o = exit_valid_q;
    assign bus.exit_code_o  = exit_code_q;
    assign bus.err_o        = err_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_diagv2_syscall_unit.sv
// Directed bench for diagv2_syscall_unit: two instances (short MAX_STR / resume-on-error,
// and defaults / stop-on-error), each with a dmem model and a byte/fetch scoreboard.
module tb_diagv2_syscall_unit;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_EXITED = 3'd6;
    localparam logic [2:0] ST_HALTED = 3'd7;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    diagv2_syscall_unit_if #(.DATA_W(64), .ADDR_W(32)) if_a ();
    diagv2_syscall_unit_if #(.DATA_W(64), .ADDR_W(32)) if_b ();
    logic [2:0] dbg_a, dbg_b;

    diagv2_syscall_unit #(.MAX_STR(4), .STOP_ON_ERR(1'b0)) u_a (
        .clk(clk), .reset(reset), .bus(if_a), .dbg_state(dbg_a)
    );
    diagv2_syscall_unit u_b (
        .clk(clk), .reset(reset), .bus(if_b), .dbg_state(dbg_b)
    );

    logic [63:0] mem_a [16];
    logic [63:0] mem_b [16];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q_a[$];
    logic [7:0]  exp_q_b[$];
    logic [31:0] exp_addr_a[$];
    logic [31:0] exp_addr_b[$];
    int          xfer_a[$];
    int          xfer_b[$];
    logic        hold_a = 1'b0, hold_b = 1'b0;
    logic [7:0]  held_a = 8'h00, held_b = 8'h00;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // dmem: read data one cycle after the strobe
    always @(posedge clk) begin
        if (if_a.mem_req_o) if_a.mem_rdata_i <= mem_a[if_a.mem_addr_o[3:0]];
        if (if_b.mem_req_o) if_b.mem_rdata_i <= mem_b[if_b.mem_addr_o[3:0]];
    end

    always @(negedge clk) begin
        if (if_a.mem_req_o) begin
            if (exp_addr_a.size() == 0) check("a_fetch_unexpected", {32'h0, if_a.mem_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("a_fetch_addr", {32'h0, if_a.mem_addr_o}, {32'h0, exp_addr_a.pop_front()});
        end
        if (hold_a && reset) begin
            check("a_hold_valid", {63'h0, if_a.tx_valid_o}, 64'h1);
            check("a_hold_data", {56'h0, if_a.tx_data_o}, {56'h0, held_a});
        end
        if (if_a.tx_valid_o && if_a.tx_ready_i) begin
            xfer_a.push_back(cyc);
            if (exp_q_a.size() == 0) check("a_tx_unexpected", {56'h0, if_a.tx_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("a_tx_byte", {56'h0, if_a.tx_data_o}, {56'h0, exp_q_a.pop_front()});
        end
        hold_a = if_a.tx_valid_o && !if_a.tx_ready_i;
        held_a = if_a.tx_data_o;
    end

    always @(negedge clk) begin
        if (if_b.mem_req_o) begin
            if (exp_addr_b.size() == 0) check("b_fetch_unexpected", {32'h0, if_b.mem_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("b_fetch_addr", {32'h0, if_b.mem_addr_o}, {32'h0, exp_addr_b.pop_front()});
        end
        if (hold_b && reset) begin
            check("b_hold_valid", {63'h0, if_b.tx_valid_o}, 64'h1);
            check("b_hold_data", {56'h0, if_b.tx_data_o}, {56'h0, held_b});
        end
        if (if_b.tx_valid_o && if_b.tx_ready_i) begin
            xfer_b.push_back(cyc);
            if (exp_q_b.size() == 0) check("b_tx_unexpected", {56'h0, if_b.tx_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("b_tx_byte", {56'h0, if_b.tx_data_o}, {56'h0, exp_q_b.pop_front()});
        end
        hold_b = if_b.tx_valid_o && !if_b.tx_ready_i;
        held_b = if_b.tx_data_o;
    end

    function automatic logic halt_of(input bit s);
        return s ? if_b.halt_o : if_a.halt_o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an ecall for one cycle; returns one edge after it was accepted.
    task automatic ecall(input bit s, input logic [63:0] id, input logic [63:0] a0);
        if (s) begin if_b.ecall_i = 1'b1; if_b.sys_id_i = id; if_b.arg0_i = a0; end
        else   begin if_a.ecall_i = 1'b1; if_a.sys_id_i = id; if_a.arg0_i = a0; end
        #1;
        check("halt_on_ecall", {63'h0, halt_of(s)}, 64'h1);
        tick();
        if (s) begin if_b.ecall_i = 1'b0; if_b.sys_id_i = '0; if_b.arg0_i = '0; end
        else   begin if_a.ecall_i = 1'b0; if_a.sys_id_i = '0; if_a.arg0_i = '0; end
    endtask

    // Count edges (acceptance edge included) until halt_o drops.
    task automatic wait_release(input bit s, input int exp_edges, input bit toggle, input string name);
        int k = 1;
        while (halt_of(s) && k < 60) begin
            tick();
            k++;
            if (toggle) begin
                if (s) if_b.tx_ready_i = ~if_b.tx_ready_i;
                else   if_a.tx_ready_i = ~if_a.tx_ready_i;
            end
        end
        check(name, 64'(k), 64'(exp_edges));
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_halt"},      {63'h0, if_a.halt_o},       64'h0);
        check({tag, "_mem_req"},   {63'h0, if_a.mem_req_o},    64'h0);
        check({tag, "_mem_addr"},  {32'h0, if_a.mem_addr_o},  64'h0);
        check({tag, "_tx_valid"},  {63'h0, if_a.tx_valid_o},   64'h0);
        check({tag, "_tx_data"},   {56'h0, if_a.tx_data_o},    64'h0);
        check({tag, "_exit_valid"},{63'h0, if_a.exit_valid_o}, 64'h0);
        check({tag, "_exit_code"}, if_a.exit_code_o,           64'h0);
        check({tag, "_err"},       {62'h0, if_a.err_o},        64'h0);
        check({tag, "_state"},     {61'h0, dbg_a},             {61'h0, ST_IDLE});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        if_a.ecall_i = 1'b0; if_a.sys_id_i = '0; if_a.arg0_i = '0; if_a.tx_ready_i = 1'b1;
        if_b.ecall_i = 1'b0; if_b.sys_id_i = '0; if_b.arg0_i = '0; if_b.tx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end

        repeat (2) @(posedge clk);
        #3;
        check_zero_a("reset");
        check("reset_b_halt", {63'h0, if_b.halt_o}, 64'h0);
        reset = 1'b1;
        tick();

        // "Hi!" from line 2
        mem_a[2] = 64'h0000_0000_0021_6948;
        exp_q_a.push_back(8'h48); exp_q_a.push_back(8'h69); exp_q_a.push_back(8'h21);
        exp_addr_a.push_back(32'd2);
        base = xfer_a.size();
        ecall(1'b0, 64'd4, 64'h10);
        wait_release(1'b0, 8, 1'b0, "hi_release_edges");
        check("hi_xfers", 64'(xfer_a.size() - base), 64'd3);
        check("hi_gap1", 64'(xfer_a[base+1] - xfer_a[base]), 64'd1);
        check("hi_gap2", 64'(xfer_a[base+2] - xfer_a[base+1]), 64'd1);
        check("hi_state_idle", {61'h0, dbg_a}, {61'h0, ST_IDLE});

        // "AB" at the tail of line 1, "C" at the head of line 2
        mem_a[1] = 64'h4241_0000_0000_0000;
        mem_a[2] = 64'h0000_0000_0000_0043;
        exp_q_a.push_back(8'h41); exp_q_a.push_back(8'h42); exp_q_a.push_back(8'h43);
        exp_addr_a.push_back(32'd1); exp_addr_a.push_back(32'd2);
        base = xfer_a.size();
        ecall(1'b0, 64'd4, 64'h0E);
        wait_release(1'b0, 10, 1'b0, "cross_release_edges");
        check("cross_gap_ab", 64'(xfer_a[base+1] - xfer_a[base]), 64'd1);
        check("cross_gap_bc", 64'(xfer_a[base+2] - xfer_a[base+1]), 64'd3);

        // "xyz" with tx_ready_i toggling every cycle
        mem_a[3] = 64'h0000_0000_007A_7978;
        exp_q_a.push_back(8'h78); exp_q_a.push_back(8'h79); exp_q_a.push_back(8'h7A);
        exp_addr_a.push_back(32'd3);
        base = xfer_a.size();
        ecall(1'b0, 64'd4, 64'h18);
        wait_release(1'b0, 10, 1'b1, "bp_release_edges");
        if_a.tx_ready_i = 1'b1;
        check("bp_xfers", 64'(xfer_a.size() - base), 64'd3);
        check("bp_gap1", 64'(xfer_a[base+1] - xfer_a[base]), 64'd2);

        // truncation at MAX_STR = 4
        mem_a[4] = 64'h0067_6665_6463_6261;
        exp_q_a.push_back(8'h61); exp_q_a.push_back(8'h62); exp_q_a.push_back(8'h63); exp_q_a.push_back(8'h64);
        exp_addr_a.push_back(32'd4);
        base = xfer_a.size();
        ecall(1'b0, 64'd4, 64'h20);
        wait_release(1'b0, 9, 1'b0, "trunc_release_edges");
        check("trunc_xfers", 64'(xfer_a.size() - base), 64'd4);
        check("trunc_err", {62'h0, if_a.err_o}, 64'h2);

        // invalid syscall, resume variant
        ecall(1'b0, 64'd55, 64'h0);
        wait_release(1'b0, 2, 1'b0, "inv_resume_release_edges");
        check("inv_resume_err", {62'h0, if_a.err_o}, 64'h3);

        // async reset during the second byte of "hello"
        mem_a[5] = 64'h0000_006F_6C6C_6568;
        exp_q_a.push_back(8'h68);
        exp_addr_a.push_back(32'd5);
        ecall(1'b0, 64'd4, 64'h28);
        repeat (3) tick();
        check("hello_2nd_valid", {63'h0, if_a.tx_valid_o}, 64'h1);
        check("hello_2nd_data", {56'h0, if_a.tx_data_o}, 64'h65);
        #2;
        reset = 1'b0;
        #1;
        check_zero_a("midreset");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (3) tick();
        check("post_reset_state", {61'h0, dbg_a}, {61'h0, ST_IDLE});
        check("post_reset_tx_valid", {63'h0, if_a.tx_valid_o}, 64'h0);

        exp_q_a.push_back(8'h41);
        ecall(1'b0, 64'd11, 64'h41);
        wait_release(1'b0, 3, 1'b0, "putc_release_edges");
        exp_q_a.push_back(8'h00);
        ecall(1'b0, 64'd11, 64'h00);
        wait_release(1'b0, 3, 1'b0, "putc_nul_release_edges");

        // EXIT, then a further ecall must be ignored
        ecall(1'b0, 64'd93, 64'd7);
        repeat (2) tick();
        check("exit_valid", {63'h0, if_a.exit_valid_o}, 64'h1);
        check("exit_code", if_a.exit_code_o, 64'd7);
        check("exit_state", {61'h0, dbg_a}, {61'h0, ST_EXITED});
        ecall(1'b0, 64'd11, 64'h42);
        repeat (4) tick();
        check("exit_halt_stuck", {63'h0, if_a.halt_o}, 64'h1);
        check("exit_state_after_ecall", {61'h0, dbg_a}, {61'h0, ST_EXITED});
        check("exit_code_kept", if_a.exit_code_o, 64'd7);

        // default build: string starting at the last byte of a line
        mem_b[6] = 64'h5100_0000_0000_0000;
        mem_b[7] = 64'h0000_0000_0000_0052;
        exp_q_b.push_back(8'h51); exp_q_b.push_back(8'h52);
        exp_addr_b.push_back(32'd6); exp_addr_b.push_back(32'd7);
        base = xfer_b.size();
        ecall(1'b1, 64'd4, 64'h37);
        wait_release(1'b1, 9, 1'b0, "b_edge_release_edges");
        check("b_edge_gap", 64'(xfer_b[base+1] - xfer_b[base]), 64'd3);

        // invalid syscall, stop variant
        ecall(1'b1, 64'd55, 64'h0);
        repeat (4) tick();
        check("b_inv_err", {62'h0, if_b.err_o}, 64'h1);
        check("b_inv_halt_stuck", {63'h0, if_b.halt_o}, 64'h1);
        check("b_inv_state", {61'h0, dbg_b}, {61'h0, ST_HALTED});

        repeat (2) tick();
        check("a_bytes_left", 64'(exp_q_a.size()), 64'd0);
        check("b_bytes_left", 64'(exp_q_b.size()), 64'd0);
        check("a_fetches_left", 64'(exp_addr_a.size()), 64'd0);
        check("b_fetches_left", 64'(exp_addr_b.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
